// File: rtl/sm_controller_v2_pkg.sv
// Shared types and encodings for the SRM controller.
// SM_CTRL_HALT_EN: when defined, opcode 111 decodes to a sticky HALT state.
package sm_ctrl_pkg;

  typedef enum logic [3:0] {
    S_WAIT, S_DECODE, S_MOV_IMM, S_GETA, S_GETB, S_GETD, S_ALU, S_WR_RD,
    S_ADDR, S_MADDR, S_PASSD, S_MEM_RD, S_MEM_WR, S_WR_MEM, S_HALT
  } state_e;

  localparam logic [2:0] NSEL_NONE = 3'b000;
  localparam logic [2:0] NSEL_RN   = 3'b001;
  localparam logic [2:0] NSEL_RD   = 3'b010;
  localparam logic [2:0] NSEL_RM   = 3'b100;

  localparam logic [1:0] VSEL_C     = 2'b00;
  localparam logic [1:0] VSEL_PC    = 2'b01;
  localparam logic [1:0] VSEL_IMM   = 2'b10;
  localparam logic [1:0] VSEL_MDATA = 2'b11;

  localparam logic [1:0] MEM_NONE  = 2'b00;
  localparam logic [1:0] MEM_READ  = 2'b01;
  localparam logic [1:0] MEM_WRITE = 2'b10;

  localparam logic [2:0] OPC_LDR  = 3'b011;
  localparam logic [2:0] OPC_STR  = 3'b100;
  localparam logic [2:0] OPC_ALU  = 3'b101;
  localparam logic [2:0] OPC_MOV  = 3'b110;
  localparam logic [2:0] OPC_HALT = 3'b111;

  localparam logic [1:0] OP_MOV_RM  = 2'b00;
  localparam logic [1:0] OP_MOV_IMM = 2'b10;
  localparam logic [1:0] OP_ADD     = 2'b00;
  localparam logic [1:0] OP_CMP     = 2'b01;
  localparam logic [1:0] OP_AND     = 2'b10;
  localparam logic [1:0] OP_MVN     = 2'b11;
  localparam logic [1:0] OP_MEM     = 2'b00;

  // First state after DECODE; S_WAIT means the instruction is illegal.
  function automatic state_e decode_entry(logic [2:0] opc, logic [1:0] op);
    case ({opc, op})
      {OPC_MOV, OP_MOV_IMM}: return S_MOV_IMM;
      {OPC_MOV, OP_MOV_RM}:  return S_GETB;
      {OPC_ALU, OP_ADD},
      {OPC_ALU, OP_AND},
      {OPC_ALU, OP_CMP}:     return S_GETA;
      {OPC_ALU, OP_MVN}:     return S_GETB;
      {OPC_LDR, OP_MEM},
      {OPC_STR, OP_MEM}:     return S_GETA;
      default: begin
`ifdef SM_CTRL_HALT_EN
        if (opc == OPC_HALT) return S_HALT;
`endif
        return S_WAIT;
      end
    endcase
  endfunction

endpackage

// File: rtl/sm_controller_v2_if.sv
// Controller <-> instruction register / datapath / memory signal bundle.
interface sm_controller_v2_if;
  logic       s;
  logic [2:0] opcode;
  logic [1:0] op;
  logic       mem_ack;
  logic       w, loada, loadb, loadc, loads, asel, bsel, write;
  logic [2:0] nsel;
  logic [1:0] vsel;
  logic       load_addr;
  logic [1:0] mem_cmd;
  logic       err;

  modport master (
    input  s, opcode, op, mem_ack,
    output w, loada, loadb, loadc, loads, asel, bsel, write,
           nsel, vsel, load_addr, mem_cmd, err
  );
  modport slave (
    output s, opcode, op, mem_ack,
    input  w, loada, loadb, loadc, loads, asel, bsel, write,
           nsel, vsel, load_addr, mem_cmd, err
  );
endinterface

// File: rtl/sm_controller_v2_mem_timer.sv
// Memory wait timer: cleared outside MEM states, flags the last allowed wait cycle.
module sm_mem_timer #(
  parameter int MEM_TO = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);
  localparam int TO_W = $clog2(MEM_TO + 1);
  localparam logic [TO_W-1:0] LAST = TO_W'(MEM_TO - 1);

  logic [TO_W-1:0] cnt_q, cnt_d;

  assign expired_o = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)                   cnt_d = '0;
    else if (en_i && !expired_o) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
endmodule

// File: rtl/sm_controller_v2.sv
// Moore FSM controller for the SRM datapath with LDR/STR memory handshake.
// SM_CTRL_HALT_EN: when defined, opcode 111 enters HALT (exit only by reset).
module sm_controller_v2
  import sm_ctrl_pkg::*;
#(
  parameter int MEM_TO = 8
) (
  input logic               clk,
  input logic               reset,
  sm_controller_v2_if.master bus
);
  state_e     state_q, state_d;
  logic [2:0] opc_q;
  logic [1:0] op_q;
  logic       err_q, err_d;
  logic       in_mem, expired;

  assign in_mem = (state_q == S_MEM_RD) || (state_q == S_MEM_WR);

  sm_mem_timer #(.MEM_TO(MEM_TO)) u_timer (
    .clk(clk), .reset(reset), .clr_i(!in_mem), .en_i(in_mem), .expired_o(expired)
  );

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= S_WAIT;
      opc_q   <= '0;
      op_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      if (state_q == S_WAIT && bus.s) begin
        opc_q <= bus.opcode;
        op_q  <= bus.op;
      end
    end

  always_comb begin
    state_d = state_q;
    err_d   = 1'b0;
    case (state_q)
      S_WAIT:    if (bus.s) state_d = S_DECODE;
      S_DECODE: begin
        state_d = decode_entry(opc_q, op_q);
        err_d   = (state_d == S_WAIT);
      end
      S_MOV_IMM: state_d = S_WAIT;
      S_GETA:    state_d = (opc_q == OPC_ALU) ? S_GETB : S_ADDR;
      S_GETB:    state_d = S_ALU;
      S_ALU:     state_d = (opc_q == OPC_ALU && op_q == OP_CMP) ? S_WAIT : S_WR_RD;
      S_WR_RD:   state_d = S_WAIT;
      S_ADDR:    state_d = S_MADDR;
      S_MADDR:   state_d = (opc_q == OPC_LDR) ? S_MEM_RD : S_GETD;
      S_GETD:    state_d = S_PASSD;
      S_PASSD:   state_d = S_MEM_WR;
      // ack takes priority over a timeout landing on the same edge
      S_MEM_RD, S_MEM_WR: begin
        if (bus.mem_ack) state_d = (state_q == S_MEM_RD) ? S_WR_MEM : S_WAIT;
        else if (expired) begin
          state_d = S_WAIT;
          err_d   = 1'b1;
        end
      end
      S_WR_MEM:  state_d = S_WAIT;
      S_HALT:    state_d = S_HALT;
      default:   state_d = S_WAIT;
    endcase
  end

  always_comb begin
    bus.w         = 1'b0;
    bus.loada     = 1'b0;
    bus.loadb     = 1'b0;
    bus.loadc     = 1'b0;
    bus.loads     = 1'b0;
    bus.asel      = 1'b0;
    bus.bsel      = 1'b0;
    bus.write     = 1'b0;
    bus.nsel      = NSEL_NONE;
    bus.vsel      = VSEL_C;
    bus.load_addr = 1'b0;
    bus.mem_cmd   = MEM_NONE;
    bus.err       = err_q;
    case (state_q)
      S_WAIT:    bus.w = 1'b1;
      S_MOV_IMM: begin bus.vsel = VSEL_IMM; bus.nsel = NSEL_RN; bus.write = 1'b1; end
      S_GETA:    begin bus.nsel = NSEL_RN; bus.loada = 1'b1; end
      S_GETB:    begin bus.nsel = NSEL_RM; bus.loadb = 1'b1; end
      S_GETD:    begin bus.nsel = NSEL_RD; bus.loadb = 1'b1; end
      S_ALU: begin
        bus.loadc = 1'b1;
        bus.loads = (opc_q == OPC_ALU);
        bus.asel  = (opc_q == OPC_MOV);
      end
      S_WR_RD:   begin bus.vsel = VSEL_C; bus.nsel = NSEL_RD; bus.write = 1'b1; end
      S_ADDR:    begin bus.bsel = 1'b1; bus.loadc = 1'b1; end
      S_MADDR:   bus.load_addr = 1'b1;
      S_PASSD:   begin bus.asel = 1'b1; bus.loadc = 1'b1; end
      S_MEM_RD:  bus.mem_cmd = MEM_READ;
      S_MEM_WR:  bus.mem_cmd = MEM_WRITE;
      S_WR_MEM:  begin bus.vsel = VSEL_MDATA; bus.nsel = NSEL_RD; bus.write = 1'b1; end
      default:   ;
    endcase
  end
endmodule

// File: tb/tb_sm_controller_v2.sv
// Scoreboard bench: expected per-cycle output words queued as stimulus is driven.
module tb_sm_controller_v2;
  localparam int MEM_TO = 8;

  typedef enum {P_WAIT, P_WAITE, P_DEC, P_MOVI, P_GETA, P_GETB, P_GETD, P_ALU, P_WRRD,
                P_ADDR, P_MADDR, P_PASSD, P_MRD, P_MWR, P_WRMEM, P_HALT} ph_e;
  typedef struct { string tag; logic [16:0] exp; } sb_t;

  logic clk = 1'b0;
  logic reset;
  sm_controller_v2_if bf();

  sm_controller_v2 #(.MEM_TO(MEM_TO)) dut (.clk(clk), .reset(reset), .bus(bf));

  always #5 clk = ~clk;

  logic [16:0] act;
  assign act = {bf.w, bf.loada, bf.loadb, bf.loadc, bf.loads, bf.asel, bf.bsel, bf.write,
                bf.nsel, bf.vsel, bf.load_addr, bf.mem_cmd, bf.err};

  int n_chk = 0;
  int n_fail = 0;
  sb_t sb[$];
  ph_e ph[$];
  bit  pa[$];

  task automatic chk(input string tag, input logic [16:0] got, input logic [16:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%05h exp=%05h", tag, got, exp);
    end
  endtask

  function automatic logic [16:0] mk(bit w, bit la, bit lb, bit lc, bit ls, bit as, bit bs,
      bit wr, logic [2:0] ns, logic [1:0] vs, bit ld, logic [1:0] mc, bit er);
    return {w, la, lb, lc, ls, as, bs, wr, ns, vs, ld, mc, er};
  endfunction

  function automatic logic [16:0] exp_of(ph_e p, logic [2:0] c);
    case (p)
      P_WAIT:  return mk(1,0,0,0,0,0,0,0,3'b000,2'b00,0,2'b00,0);
      P_WAITE: return mk(1,0,0,0,0,0,0,0,3'b000,2'b00,0,2'b00,1);
      P_MOVI:  return mk(0,0,0,0,0,0,0,1,3'b001,2'b10,0,2'b00,0);
      P_GETA:  return mk(0,1,0,0,0,0,0,0,3'b001,2'b00,0,2'b00,0);
      P_GETB:  return mk(0,0,1,0,0,0,0,0,3'b100,2'b00,0,2'b00,0);
      P_GETD:  return mk(0,0,1,0,0,0,0,0,3'b010,2'b00,0,2'b00,0);
      P_ALU:   return mk(0,0,0,1,c==3'b101,c==3'b110,0,0,3'b000,2'b00,0,2'b00,0);
      P_WRRD:  return mk(0,0,0,0,0,0,0,1,3'b010,2'b00,0,2'b00,0);
      P_ADDR:  return mk(0,0,0,1,0,0,1,0,3'b000,2'b00,0,2'b00,0);
      P_MADDR: return mk(0,0,0,0,0,0,0,0,3'b000,2'b00,1,2'b00,0);
      P_PASSD: return mk(0,0,0,1,0,1,0,0,3'b000,2'b00,0,2'b00,0);
      P_MRD:   return mk(0,0,0,0,0,0,0,0,3'b000,2'b00,0,2'b01,0);
      P_MWR:   return mk(0,0,0,0,0,0,0,0,3'b000,2'b00,0,2'b10,0);
      P_WRMEM: return mk(0,0,0,0,0,0,0,1,3'b010,2'b11,0,2'b00,0);
      default: return '0;  // DEC, HALT
    endcase
  endfunction

  task automatic add(ph_e p, bit a = 1'b0);
    ph.push_back(p);
    pa.push_back(a);
  endtask

  task automatic add_mem(ph_e p, int n, bit ack);
    if (ack) begin
      for (int i = 0; i < n; i++) add(p);
      add(p, 1'b1);
    end else
      for (int i = 0; i < MEM_TO; i++) add(p);
  endtask

  task automatic build(logic [2:0] c, logic [1:0] o, int n, bit ack);
    bit err = 1'b0;
    bit halt = 1'b0;
    ph.delete();
    pa.delete();
    add(P_DEC);
    case ({c, o})
      5'b110_10: add(P_MOVI);
      5'b110_00: begin add(P_GETB); add(P_ALU); add(P_WRRD); end
      5'b101_00, 5'b101_10: begin add(P_GETA); add(P_GETB); add(P_ALU); add(P_WRRD); end
      5'b101_01: begin add(P_GETA); add(P_GETB); add(P_ALU); end
      5'b101_11: begin add(P_GETB); add(P_ALU); add(P_WRRD); end
      5'b011_00: begin
        add(P_GETA); add(P_ADDR); add(P_MADDR); add_mem(P_MRD, n, ack);
        if (ack) add(P_WRMEM); else err = 1'b1;
      end
      5'b100_00: begin
        add(P_GETA); add(P_ADDR); add(P_MADDR); add(P_GETD); add(P_PASSD);
        add_mem(P_MWR, n, ack);
        err = !ack;
      end
      default: begin
`ifdef SM_CTRL_HALT_EN
        halt = (c == 3'b111);
`endif
        err = !halt;
      end
    endcase
    if (halt) for (int i = 0; i < 6; i++) add(P_HALT);
    else begin
      if (err) add(P_WAITE);
      add(P_WAIT);
    end
  endtask

  // hold keeps s high in every non-WAIT cycle; lim truncates the trace
  task automatic run(string nm, logic [2:0] c, logic [1:0] o, int n, bit ack, bit hold, int lim);
    build(c, o, n, ack);
    @(negedge clk);
    bf.opcode = c; bf.op = o; bf.s = 1'b1; bf.mem_ack = 1'b0;
    for (int i = 0; i < ph.size() && i < lim; i++) begin
      @(posedge clk); #1;
      bf.opcode  = ~c;
      bf.op      = ~o;
      bf.s       = hold && !(ph[i] == P_WAIT || ph[i] == P_WAITE);
      bf.mem_ack = pa[i];
      sb.push_back('{$sformatf("%s#%0d_%s", nm, i, ph[i].name()), exp_of(ph[i], c)});
    end
    @(negedge clk); #1;
    if (sb.size() != 0) begin
      chk({nm, "_drain"}, 17'(sb.size()), 17'd0);
      sb.delete();
    end
  endtask

  always @(negedge clk)
    if (sb.size() != 0) begin
      sb_t e;
      e = sb.pop_front();
      chk(e.tag, act, e.exp);
    end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; bf.s = 1'b0; bf.opcode = '0; bf.op = '0; bf.mem_ack = 1'b0;
    #3;
    chk("reset_state", act, exp_of(P_WAIT, 3'b000));
    repeat (2) @(posedge clk);
    @(negedge clk); reset = 1'b0;
    @(negedge clk); #1;
    chk("idle_after_reset", act, exp_of(P_WAIT, 3'b000));

    run("mov_imm", 3'b110, 2'b10, 0, 1, 0, 99);
    run("mov_rm",  3'b110, 2'b00, 0, 1, 0, 99);
    run("add_s_held", 3'b101, 2'b00, 0, 1, 1, 99);
    run("and",     3'b101, 2'b10, 0, 1, 0, 99);
    run("cmp",     3'b101, 2'b01, 0, 1, 0, 99);
    run("mvn",     3'b101, 2'b11, 0, 1, 0, 99);
    run("ldr_n0",  3'b011, 2'b00, 0, 1, 0, 99);
    run("ldr_n2",  3'b011, 2'b00, 2, 1, 0, 99);
    run("ldr_ack_on_last", 3'b011, 2'b00, MEM_TO - 1, 1, 0, 99);
    run("str_n1",  3'b100, 2'b00, 1, 1, 0, 99);
    run("str_timeout", 3'b100, 2'b00, 0, 0, 0, 99);
    run("ill_110_01", 3'b110, 2'b01, 0, 1, 0, 99);
    run("ill_000",    3'b000, 2'b00, 0, 1, 0, 99);
    run("ill_ldr_op1", 3'b011, 2'b01, 0, 1, 0, 99);

    // stop in the second MEM_RD cycle, then reset between edges
    run("ldr_rst", 3'b011, 2'b00, 0, 0, 0, 6);
    chk("pre_rst_mem_rd", act, exp_of(P_MRD, 3'b011));
    reset = 1'b1;
    #1;
    chk("rst_mid_mem", act, exp_of(P_WAIT, 3'b000));
    @(posedge clk); #1;
    chk("rst_held", act, exp_of(P_WAIT, 3'b000));
    @(negedge clk); reset = 1'b0;
    run("after_rst", 3'b110, 2'b10, 0, 1, 0, 99);

    run("op111", 3'b111, 2'b01, 0, 1, 1, 99);
    bf.s = 1'b0;
    reset = 1'b1;
    #1;
    chk("op111_reset", act, exp_of(P_WAIT, 3'b000));
    @(negedge clk); reset = 1'b0;
    run("final_cmp", 3'b101, 2'b01, 0, 1, 0, 99);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
